perceptron_ctrl: RTL and testbench

Control and loading stage directly upstream of the perceptron datapath. Takes a parallel weight/bias set over a valid/ready interface and serializes it, MSB first, into the datapath's bit-serial shift registers. Then streams input sample pairs through the datapath with valid/ready flow control and produces a valid-qualified decision stream from the datapath's registered decision bit.

---
 rtl/perceptron_pkg.sv | 26 ++
 rtl/perceptron_serializer.sv | 45 ++++
 rtl/perceptron_ctrl.sv | 159 +++++++++++++++
 tb/tb_perceptron_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared state encoding and shift-select codes for perceptron_ctrl
//
// Purpose: types and constants used by the controller and its serializer.
//   state_t       : controller FSM states
//   SEL_*         : datapath shift-select codes driven on W1W0b_en_o
//   is_load_state : true while a weight word is being shifted out
package perceptron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_W0 = 3'd2,
    ST_LOAD_W1 = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_W0   = 2'b10;
  localparam logic [1:0] SEL_W1   = 2'b11;

  function automatic logic is_load_state(input state_t s);
    return (s == ST_LOAD_B) || (s == ST_LOAD_W0) || (s == ST_LOAD_W1);
  endfunction

endpackage

// File: rtl/perceptron_serializer.sv
// rtl/perceptron_serializer.sv - parallel-load MSB-first shift register with bit counter
//
// Purpose: holds one WIDTH-bit word and presents it one bit per shift cycle,
// MSB first, flagging the cycle in which the last bit is on the output.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load, data : parallel load of a new word (wins over shift), clears counter
//   shift      : advance one bit this cycle
//   msb        : current serial bit
//   done       : last bit of the word is being presented and shifted this cycle
module perceptron_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  assign msb  = sr[WIDTH-1];
  assign done = shift && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[WIDTH-2:0], 1'b0};
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/perceptron_ctrl.sv
// rtl/perceptron_ctrl.sv - weight loader and sample sequencer for the perceptron datapath
//
// Purpose: accepts a weight set, shifts bias, W0, W1 MSB first into the
// datapath, then streams sample pairs and returns a valid-qualified decision.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   load_valid_i/load_ready_o, load_*  : weight-set handshake and words
//   sample_valid_i/sample_ready_o, x*  : sample-pair handshake and inputs
//   W1W0b_en_o, b_o, W0_o, W1_o        : datapath shift select and serial bit
//   X0_o, X1_o                         : sample pass-through to datapath
//   en_in_path_o, en_out_path_o        : datapath input/output register enables
//   Y_i, y_valid_o, y_o                : datapath decision and qualified output
//   weights_loaded_o                   : a complete weight set is in the datapath
module perceptron_ctrl
  import perceptron_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_b_i,
  input  logic [WIDTH-1:0] load_w0_i,
  input  logic [WIDTH-1:0] load_w1_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  input  logic [WIDTH-1:0] sample_x0_i,
  input  logic [WIDTH-1:0] sample_x1_i,
  output logic [1:0]       W1W0b_en_o,
  output logic             b_o,
  output logic             W0_o,
  output logic             W1_o,
  output logic [WIDTH-1:0] X0_o,
  output logic [WIDTH-1:0] X1_o,
  output logic             en_in_path_o,
  output logic             en_out_path_o,
  input  logic             Y_i,
  output logic             y_valid_o,
  output logic             y_o,
  output logic             weights_loaded_o
);

  state_t           state;
  logic [1:0]       sel_q;
  logic             loaded_q;
  logic             en_out_q;
  logic             y_valid_q;
  logic [WIDTH-1:0] hold_w0;
  logic [WIDTH-1:0] hold_w1;

  logic             load_hs;
  logic             sample_hs;
  logic             ser_load;
  logic             ser_shift;
  logic             ser_done;
  logic             ser_msb;
  logic [WIDTH-1:0] ser_data;

  // A reload in RUN must not disturb a sample whose output register update
  // is still pending, and never competes with a sample offered this cycle.
  assign load_ready_o   = !reset && ((state == ST_IDLE) ||
                          ((state == ST_RUN) && !en_out_q && !sample_valid_i));
  assign sample_ready_o = !reset && (state == ST_RUN);
  assign load_hs        = load_valid_i && load_ready_o;
  assign sample_hs      = sample_valid_i && sample_ready_o;

  assign ser_shift = is_load_state(state);

  // The next word is loaded in the same cycle the previous one finishes so
  // the three words leave back to back without a gap.
  always_comb begin
    ser_load = 1'b0;
    ser_data = load_b_i;
    if (load_hs) begin
      ser_load = 1'b1;
      ser_data = load_b_i;
    end else if (ser_done && (state == ST_LOAD_B)) begin
      ser_load = 1'b1;
      ser_data = hold_w0;
    end else if (ser_done && (state == ST_LOAD_W0)) begin
      ser_load = 1'b1;
      ser_data = hold_w1;
    end
  end

  perceptron_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load),
    .shift (ser_shift),
    .data  (ser_data),
    .msb   (ser_msb),
    .done  (ser_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_q     <= SEL_HOLD;
      loaded_q  <= 1'b0;
      en_out_q  <= 1'b0;
      y_valid_q <= 1'b0;
      hold_w0   <= '0;
      hold_w1   <= '0;
    end else begin
      en_out_q  <= sample_hs;
      y_valid_q <= en_out_q;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (load_hs) begin
            hold_w0  <= load_w0_i;
            hold_w1  <= load_w1_i;
            state    <= ST_LOAD_B;
            sel_q    <= SEL_B;
            loaded_q <= 1'b0;
          end
        end
        ST_LOAD_B: begin
          if (ser_done) begin
            state <= ST_LOAD_W0;
            sel_q <= SEL_W0;
          end
        end
        ST_LOAD_W0: begin
          if (ser_done) begin
            state <= ST_LOAD_W1;
            sel_q <= SEL_W1;
          end
        end
        ST_LOAD_W1: begin
          if (ser_done) begin
            state    <= ST_RUN;
            sel_q    <= SEL_HOLD;
            loaded_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          sel_q <= SEL_HOLD;
        end
      endcase
    end
  end

  assign W1W0b_en_o       = sel_q;
  assign b_o              = ser_msb;
  assign W0_o             = ser_msb;
  assign W1_o             = ser_msb;
  assign X0_o             = sample_x0_i;
  assign X1_o             = sample_x1_i;
  assign en_in_path_o     = sample_hs;
  assign en_out_path_o    = en_out_q;
  assign y_valid_o        = y_valid_q;
  // Y_i is already registered by the datapath, so it is forwarded directly.
  assign y_o              = y_valid_q & Y_i;
  assign weights_loaded_o = loaded_q;

endmodule

// File: tb/tb_perceptron_ctrl.sv
// tb/tb_perceptron_ctrl.sv - self-checking bench for perceptron_ctrl
module tb_perceptron_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_b = '0, load_w0 = '0, load_w1 = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [W-1:0] sample_x0 = '0, sample_x1 = '0;
  logic [1:0]   sel;
  logic         b_bit, w0_bit, w1_bit;
  logic [W-1:0] x0_out, x1_out;
  logic         en_in, en_out;
  logic         dp_y = 1'b0;
  logic         y_valid, y;
  logic         weights_loaded;

  always #5 clk = ~clk;

  perceptron_ctrl #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_valid_i     (load_valid),
    .load_ready_o     (load_ready),
    .load_b_i         (load_b),
    .load_w0_i        (load_w0),
    .load_w1_i        (load_w1),
    .sample_valid_i   (sample_valid),
    .sample_ready_o   (sample_ready),
    .sample_x0_i      (sample_x0),
    .sample_x1_i      (sample_x1),
    .W1W0b_en_o       (sel),
    .b_o              (b_bit),
    .W0_o             (w0_bit),
    .W1_o             (w1_bit),
    .X0_o             (x0_out),
    .X1_o             (x1_out),
    .en_in_path_o     (en_in),
    .en_out_path_o    (en_out),
    .Y_i              (dp_y),
    .y_valid_o        (y_valid),
    .y_o              (y),
    .weights_loaded_o (weights_loaded)
  );

  // Datapath stand-in: rebuilds weights from the serial stream and computes
  // sign(b + w0*x0 + w1*x1) into a registered decision.
  logic signed [W-1:0] dp_b = '0, dp_w0 = '0, dp_w1 = '0, dp_x0 = '0, dp_x1 = '0;
  always @(posedge clk) begin
    case (sel)
      2'b01: dp_b  <= {dp_b[W-2:0], b_bit};
      2'b10: dp_w0 <= {dp_w0[W-2:0], w0_bit};
      2'b11: dp_w1 <= {dp_w1[W-2:0], w1_bit};
      default: ;
    endcase
    if (en_in) begin
      dp_x0 <= x0_out;
      dp_x1 <= x1_out;
    end
    if (en_out) dp_y <= ((int'(dp_b) + int'(dp_w0) * int'(dp_x0) + int'(dp_w1) * int'(dp_x1)) >= 0);
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: mode 0 idle, 1 loading (lidx = cycle within 3*W), 2 run.
  int           mode = 0;
  int           lidx = 0;
  bit           m_loaded = 0, hs1 = 0, hs2 = 0, started = 0;
  logic [W-1:0] ld_b = '0, ld_w0 = '0, ld_w1 = '0;
  logic [W-1:0] m_b = '0, m_w0 = '0, m_w1 = '0;
  logic [W-1:0] x1a = '0, x1b = '0, x2a = '0, x2b = '0;

  function automatic bit decide(input logic [W-1:0] b, w0, w1, x0, x1);
    int s;
    s = int'($signed(b)) + int'($signed(w0)) * int'($signed(x0)) + int'($signed(w1)) * int'($signed(x1));
    return s >= 0;
  endfunction

  function automatic bit f_load_ready();
    return !reset && (mode == 0 || (mode == 2 && !hs1 && !sample_valid));
  endfunction

  function automatic bit f_sample_ready();
    return !reset && mode == 2;
  endfunction

  function automatic logic f_bit();
    logic [W-1:0] wd;
    wd = (lidx < W) ? ld_b : (lidx < 2 * W) ? ld_w0 : ld_w1;
    return wd[W - 1 - (lidx % W)];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      mode <= 0; lidx <= 0; hs1 <= 0; hs2 <= 0; m_loaded <= 0; started <= 1;
    end else begin
      hs2 <= hs1; x2a <= x1a; x2b <= x1b;
      hs1 <= f_sample_ready() && sample_valid;
      x1a <= sample_x0; x1b <= sample_x1;
      if (mode == 1) begin
        lidx <= lidx + 1;
        if (lidx == 3 * W - 1) begin
          mode <= 2; m_loaded <= 1; m_b <= ld_b; m_w0 <= ld_w0; m_w1 <= ld_w1;
        end
      end else if (f_load_ready() && load_valid) begin
        ld_b <= load_b; ld_w0 <= load_w0; ld_w1 <= load_w1;
        mode <= 1; lidx <= 0; m_loaded <= 0;
      end
    end
  end

  // Observed streams for the literal checks.
  logic [2:0] stream[$];
  bit         yq[$];
  int         ycyc[$];

  always @(negedge clk) begin
    if (started) begin
      chk("load_ready", load_ready, f_load_ready());
      chk("sample_ready", sample_ready, f_sample_ready());
      chk("en_in", en_in, f_sample_ready() && sample_valid);
      chk("en_out", en_out, hs1);
      chk("y_valid", y_valid, hs2);
      chk("y", y, hs2 ? decide(m_b, m_w0, m_w1, x2a, x2b) : 1'b0);
      chk("sel", sel, (mode == 1) ? (lidx / W + 1) : 0);
      if (mode == 1) begin
        chk("b_bit", b_bit, f_bit());
        chk("w0_bit", w0_bit, f_bit());
        chk("w1_bit", w1_bit, f_bit());
      end
      chk("loaded", weights_loaded, m_loaded);
      chk("x0_pass", x0_out, sample_x0);
      chk("x1_pass", x1_out, sample_x1);
      if (sel != 2'b00) stream.push_back({sel, b_bit});
      if (y_valid) begin
        yq.push_back(y);
        ycyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] b, w0, w1);
    bit got;
    got = 0;
    load_valid = 1'b1; load_b = b; load_w0 = w0; load_w1 = w1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load_ready) begin
        got = 1;
        break;
      end
    end
    chk("load_handshake_timeout", got, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_b = W'($urandom); load_w0 = W'($urandom); load_w1 = W'($urandom);
  endtask

  task automatic send(input logic [W-1:0] x0, x1);
    sample_valid = 1'b1; sample_x0 = x0; sample_x1 = x1;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] lit;
    lit = 24'h0502FE;

    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_loaded", weights_loaded, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y", y, 0);
    chk("idle_load_ready", load_ready, 1);
    step();

    // Samples offered before any load must be ignored.
    sample_valid = 1'b1; sample_x0 = 8'd3; sample_x1 = 8'd1;
    repeat (4) step();
    sample_valid = 1'b0;
    step();

    stream.delete();
    do_load(8'h05, 8'h02, 8'hFE);
    repeat (3 * W) step();
    @(negedge clk);
    chk("stream_len", stream.size(), 24);
    for (int i = 0; i < 24 && i < stream.size(); i++)
      chk("stream_lit", stream[i], {2'(i / 8 + 1), lit[23 - i]});
    chk("loaded_after", weights_loaded, 1);
    step();

    yq.delete(); ycyc.delete();
    send(8'd3, 8'd1);
    repeat (4) step();
    chk("y_single_cnt", yq.size(), 1);
    if (yq.size() >= 1) chk("y_single", yq[0], 1);

    yq.delete(); ycyc.delete();
    send(-8'sd4, 8'd0);
    send(8'd3, 8'd1);
    send(8'd0, 8'd0);
    repeat (4) step();
    chk("y_burst_cnt", yq.size(), 3);
    if (yq.size() == 3) begin
      chk("y_burst0", yq[0], 0);
      chk("y_burst1", yq[1], 1);
      chk("y_burst2", yq[2], 1);
      chk("y_burst_consec", ycyc[2] - ycyc[0], 2);
    end

    // Reload requested while a sample is in flight.
    send(8'd1, 8'd1);
    load_valid = 1'b1;
    @(negedge clk);
    chk("load_ready_inflight", load_ready, 0);
    do_load(W'($urandom), W'($urandom), W'($urandom));
    repeat (3 * W) step();

    // Random traffic with occasional reload requests.
    for (int i = 0; i < 400; i++) begin
      sample_valid = ($urandom % 4) != 0;
      sample_x0 = W'($urandom); sample_x1 = W'($urandom);
      load_valid = ($urandom % 40) == 0;
      load_b = W'($urandom); load_w0 = W'($urandom); load_w1 = W'($urandom);
      step();
    end
    sample_valid = 1'b0; load_valid = 1'b0;
    repeat (3 * W + 4) step();

    // Reset in the middle of a load.
    do_load(8'h11, 8'h22, 8'h33);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_sel", sel, 0);
    chk("abort_loaded", weights_loaded, 0);
    chk("abort_load_ready", load_ready, 1);
    step();

    // Fresh load, then reset with samples in flight, then reload and run.
    do_load(8'h05, 8'h02, 8'hFE);
    repeat (3 * W) step();
    sample_valid = 1'b1; sample_x0 = 8'd3; sample_x1 = 8'd1;
    step();
    sample_x0 = -8'sd4; sample_x1 = 8'd0;
    step();
    sample_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    do_load(8'h05, 8'h02, 8'hFE);
    repeat (3 * W) step();
    yq.delete();
    send(-8'sd4, 8'd0);
    repeat (4) step();
    chk("y_after_reload_cnt", yq.size(), 1);
    if (yq.size() >= 1) chk("y_after_reload", yq[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
